// File: rtl/addsub_pkg.sv
// Shared types for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ABS  = 2'b10,
    MODE_SUBB = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RUN2,
    S_DONE
  } state_t;

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub.
// slave = arithmetic block side, master = producer/consumer side.
interface serial_addsub_if #(parameter int N = 8);
  import addsub_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  mode_t        mode;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;

  modport slave (
    input  in_valid, a, b, mode, cin, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero, neg
  );

  modport master (
    output in_valid, a, b, mode, cin, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero, neg
  );
endinterface

// File: rtl/addsub_digit.sv
// K-bit ripple-carry slice built from 1-bit full adders.
// c_msb is the carry into the top bit, needed for signed overflow.
module addsub_digit #(
  parameter int K = 2
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  output logic [K-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  // Ripple the carry through K full adders.
  always_comb begin
    logic [K:0] c;
    c     = '0;
    s     = '0;
    c[0]  = cin;
    for (int unsigned i = 0; i < K; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout  = c[K];
    c_msb = c[K-1];
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial ADD / SUB / SUBB / |a-b|, K bits per clock over N bits.
// Optional macro ADDSUB_SAT_EN: clamp signed overflow in ADD/SUB/SUBB.
module serial_addsub #(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic             clk,
  input  logic             rst,
  serial_addsub_if.slave   bus
);
  import addsub_pkg::*;

  localparam int D  = N / K;
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  state_t        state_q, state_d;
  mode_t         mode_q, mode_d;
  logic [N-1:0]  opa_q, opa_d;
  logic [N-1:0]  opb_q, opb_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cin_q, cin_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;
  logic          neg_q, neg_d;
  logic          ovalid_q, ovalid_d;

  logic [K-1:0]  dig_s;
  logic          dig_cin, dig_cout, dig_cmsb;
  logic [N-1:0]  res_next;
  logic [N-1:0]  arith_res;
  logic          arith_ovf;
  logic          last;

  addsub_digit #(.K(K)) u_digit (
    .a     (opa_q[K-1:0]),
    .b     (opb_q[K-1:0]),
    .cin   (dig_cin),
    .s     (dig_s),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  // Slice carry-in, shifted result and overflow/clamp of the final digit.
  always_comb begin
    dig_cin = carry_q;
    if (cnt_q == '0) begin
      if (state_q == S_RUN && (mode_q == MODE_ADD || mode_q == MODE_SUBB))
        dig_cin = cin_q;
      else
        dig_cin = 1'b1;
    end
    res_next  = (res_q >> K) | (N'(dig_s) << (N - K));
    arith_ovf = dig_cmsb ^ dig_cout;
`ifdef ADDSUB_SAT_EN
    // Wrapped MSB is the opposite of the true sign, so it selects the limit.
    arith_res = arith_ovf ? {~res_next[N-1], {(N-1){res_next[N-1]}}} : res_next;
`else
    arith_res = res_next;
`endif
    last = (cnt_q == CW'(D - 1));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    cin_d    = cin_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovalid_d = ovalid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mode_d  = bus.mode;
          cin_d   = bus.cin;
          a_d     = bus.a;
          b_d     = bus.b;
          opa_d   = bus.a;
          opb_d   = (bus.mode == MODE_ADD) ? bus.b : ~bus.b;
          res_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN, S_RUN2: begin
        opa_d   = opa_q >> K;
        opb_d   = opb_q >> K;
        res_d   = res_next;
        carry_d = dig_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          if (state_q == S_RUN && mode_q == MODE_ABS && !dig_cout) begin
            // a < b: recompute as b - a straight away, no idle cycle.
            opa_d   = b_q;
            opb_d   = ~a_q;
            res_d   = '0;
            cnt_d   = '0;
            state_d = S_RUN2;
          end else begin
            state_d  = S_DONE;
            ovalid_d = 1'b1;
            if (state_q == S_RUN2) begin
              result_d = res_next;
              cout_d   = 1'b0;
              ovf_d    = 1'b0;
              neg_d    = 1'b1;
              zero_d   = (res_next == '0);
            end else if (mode_q == MODE_ABS) begin
              result_d = res_next;
              cout_d   = 1'b1;
              ovf_d    = 1'b0;
              neg_d    = 1'b0;
              zero_d   = (res_next == '0);
            end else begin
              result_d = arith_res;
              cout_d   = dig_cout;
              ovf_d    = arith_ovf;
              neg_d    = arith_res[N-1];
              zero_d   = (arith_res == '0);
            end
          end
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          ovalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_ADD;
      opa_q    <= '0;
      opb_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = ovalid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub (N=8, K=2): vector table + scoreboard queue,
// plus backpressure and mid-operation reset sequences.
module tb_serial_addsub;
  import addsub_pkg::*;

  logic clk;
  logic rst;

  serial_addsub_if #(.N(8)) bus ();

  serial_addsub #(.N(8), .K(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    mode_t      mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       neg;
    int         lat;
  } vec_t;

  vec_t vecs[11];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation, wait for its result, optionally stall the consumer
  // for `hold` cycles while pulsing in_valid, then complete the handshake.
  task automatic do_op(input vec_t v, input int hold);
    int   lat;
    bit   seen;
    vec_t e;
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.a         = v.a;
    bus.b         = v.b;
    bus.mode      = v.mode;
    bus.cin       = v.cin;
    bus.out_ready = 1'b0;
    sb.push_back(v);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 8'h00;
    bus.b        = 8'h00;
    seen = 0;
    lat  = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (!bus.out_valid) check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid) begin
        seen = 1;
        lat  = c;
      end
    end
    e = sb.pop_front();
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL timeout: out_valid never rose for a=%0h b=%0h", v.a, v.b);
    end else begin
      check("latency", 32'(lat), 32'(e.lat));
      check("result", 32'(bus.result), 32'(e.res));
      check("cout", 32'(bus.cout), 32'(e.cout));
      check("ovf", 32'(bus.ovf), 32'(e.ovf));
      check("zero", 32'(bus.zero), 32'(e.zero));
      check("neg", 32'(bus.neg), 32'(e.neg));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.in_valid = (h % 2 == 0);
      bus.a        = 8'hAA;
      bus.b        = 8'h55;
      bus.mode     = MODE_SUB;
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_ready", 32'(bus.in_ready), 32'd0);
      check("hold_result", 32'(bus.result), 32'(e.res));
      check("hold_flags", {28'd0, bus.cout, bus.ovf, bus.zero, bus.neg},
            {28'd0, e.cout, e.ovf, e.zero, e.neg});
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("release_valid", 32'(bus.out_valid), 32'd0);
    check("release_ready", 32'(bus.in_ready), 32'd1);
    if (hold > 0) begin
      // Ignored pulses must not have launched an operation.
      for (int c = 0; c < 6; c++) begin
        @(posedge clk);
        #1;
        check("no_ghost_op", 32'(bus.out_valid), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{MODE_ADD,  8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, 1'b1, 4};
    vecs[1] = '{MODE_SUB,  8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 4};
    vecs[2] = '{MODE_SUBB, 8'h20, 8'h10, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    vecs[3] = '{MODE_ABS,  8'h09, 8'h03, 1'b0, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    vecs[4] = '{MODE_ABS,  8'h03, 8'h09, 1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 8};
    vecs[5] = '{MODE_ABS,  8'h77, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4};
`ifdef ADDSUB_SAT_EN
    vecs[6] = '{MODE_ADD,  8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    vecs[7] = '{MODE_SUB,  8'h80, 8'h01, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 4};
`else
    vecs[6] = '{MODE_ADD,  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 4};
    vecs[7] = '{MODE_SUB,  8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 4};
`endif
    vecs[8]  = '{MODE_ADD, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    vecs[9]  = '{MODE_SUB, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4};
    vecs[10] = '{MODE_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 4};

    bus.in_valid  = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.mode      = MODE_ADD;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", {28'd0, bus.cout, bus.ovf, bus.zero, bus.neg}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) do_op(vecs[i], 0);

    // Consumer stall with in_valid pulses in DONE.
    do_op(vecs[2], 5);

    // Reset after two digits of an ADD.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 8'h5A;
    bus.b        = 8'h3C;
    bus.mode     = MODE_ADD;
    bus.cin      = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_idle", 32'(bus.in_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check("abort_no_output", 32'(bus.out_valid), 32'd0);
    end
    do_op(vecs[10], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
